// File: rtl/dsp_top.sv
// Sequenced signed multiply / shift / accumulate unit built around one (W/2+1)-bit
// signed multiplier core, iterated over operand halves, with optional output delay.
module dsp_top #(
    parameter int WIDTH            = 16,
    parameter int PPM_TYPE         = 0,
    parameter int SHIFT_BITS       = 2,
    parameter int PIPE_STAGE_WIDTH = 2,
    parameter int PIPELINE_BITS    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [WIDTH-1:0]            aa,
    input  logic [WIDTH-1:0]            bb,
    input  logic [2*WIDTH-1:0]          cc,
    input  logic                        mac,
    input  logic [SHIFT_BITS-1:0]       shift_amount,
    input  logic                        shift_dir,
    input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
    output logic [2*WIDTH-1:0]          out,
    output logic                        valid
);

    localparam int W    = WIDTH;
    localparam int H    = W / 2;
    localparam int C    = H + 1;
    localparam int CP   = 2 * C;
    localparam int NB   = C / 2 + 1;
    localparam int MAXP = (1 << PIPELINE_BITS) - 1;

    // Modified Baugh-Wooley: sign-row/column cross terms inverted, fixed ones at C and 2C-1.
    function automatic logic signed [CP-1:0] f_mul_bw(input logic signed [C-1:0] a,
                                                      input logic signed [C-1:0] b);
        logic [CP-1:0] acc;
        logic [CP-1:0] row;
        logic          pbit;
        acc        = '0;
        acc[C]     = 1'b1;
        acc[CP-1]  = 1'b1;
        for (int i = 0; i < C; i++) begin
            row = '0;
            for (int j = 0; j < C; j++) begin
                pbit = a[j] & b[i];
                if ((i == C - 1) != (j == C - 1))
                    pbit = ~pbit;
                row[j] = pbit;
            end
            acc = acc + (row << i);
        end
        return acc;
    endfunction

    function automatic logic signed [CP-1:0] f_mul_booth(input logic signed [C-1:0] a,
                                                         input logic signed [C-1:0] b);
        logic        [2*NB:0] bx;
        logic signed [CP-1:0] ae;
        logic signed [CP-1:0] pp;
        logic signed [CP-1:0] acc;
        bx  = {{(2*NB-C){b[C-1]}}, b, 1'b0};
        ae  = {{(CP-C){a[C-1]}}, a};
        acc = '0;
        for (int k = 0; k < NB; k++) begin
            case (bx[2*k+2 -: 3])
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae <<< 1;
                3'b100:         pp = -(ae <<< 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * k));
        end
        return acc;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_PIPE} state_t;

    state_t                     r_state;
    logic [W-1:0]               r_aa;
    logic [W-1:0]               r_bb;
    logic [2*W-1:0]             r_cc;
    logic [1:0]                 r_mode;
    logic                       r_mac;
    logic [SHIFT_BITS-1:0]      r_sh;
    logic                       r_dir;
    logic [PIPELINE_BITS-1:0]   r_ps;
    logic [PIPELINE_BITS-1:0]   r_dly;
    logic [1:0]                 r_pass;
    logic [1:0]                 r_last;
    logic [2*W-1:0]             r_acc;
    logic [2*W-1:0]             r_res;

    logic signed [C-1:0]        w_a;
    logic signed [C-1:0]        w_b;
    logic [1:0]                 w_tsh;
    logic signed [CP-1:0]       w_core;
    logic [2*W-1:0]             w_term_ext;
    logic [2*W-1:0]             w_term;
    logic [2*W-1:0]             w_prod;
    logic [2*W-1:0]             w_s;
    logic [2*W-1:0]             w_r;
    logic [PIPELINE_BITS-1:0]   w_ps_eff;
    logic [1:0]                 w_last;
    logic                       w_done;
    logic                       w_accept;
    int                         w_ps_int;

    // Operand halves: lo halves are unsigned (zero-extended), hi halves carry the sign.
    always_comb begin
        w_a   = r_aa[H:0];
        w_b   = r_bb[H:0];
        w_tsh = 2'd0;
        case (r_mode)
            2'd0: ;
            2'd1: begin
                if (r_pass == 2'd0) begin
                    w_b = {1'b0, r_bb[H-1:0]};
                end else begin
                    w_b   = {r_bb[W-1], r_bb[W-1:H]};
                    w_tsh = 2'd1;
                end
            end
            default: begin
                case (r_pass)
                    2'd0: begin
                        w_a = {1'b0, r_aa[H-1:0]};
                        w_b = {1'b0, r_bb[H-1:0]};
                    end
                    2'd1: begin
                        w_a   = {1'b0, r_aa[H-1:0]};
                        w_b   = {r_bb[W-1], r_bb[W-1:H]};
                        w_tsh = 2'd1;
                    end
                    2'd2: begin
                        w_a   = {r_aa[W-1], r_aa[W-1:H]};
                        w_b   = {1'b0, r_bb[H-1:0]};
                        w_tsh = 2'd1;
                    end
                    default: begin
                        w_a   = {r_aa[W-1], r_aa[W-1:H]};
                        w_b   = {r_bb[W-1], r_bb[W-1:H]};
                        w_tsh = 2'd2;
                    end
                endcase
            end
        endcase
    end

    generate
        if (PPM_TYPE == 1) begin : g_booth
            assign w_core = f_mul_booth(w_a, w_b);
        end else begin : g_bw
            assign w_core = f_mul_bw(w_a, w_b);
        end
    endgenerate

    assign w_term_ext = {{(2*W-CP){w_core[CP-1]}}, w_core};

    always_comb begin
        case (w_tsh)
            2'd1:    w_term = w_term_ext << H;
            2'd2:    w_term = w_term_ext << W;
            default: w_term = w_term_ext;
        endcase
    end

    assign w_prod = r_acc + w_term;

    always_comb begin
        if (r_dir)
            w_s = $unsigned($signed(w_prod) >>> r_sh);
        else
            w_s = w_prod << r_sh;
    end

    assign w_r = w_s + (r_mac ? out : r_cc);

    always_comb begin
        w_ps_int = int'(pipe_stages);
        if (w_ps_int > MAXP)
            w_ps_int = MAXP;
        w_ps_eff = PIPELINE_BITS'(w_ps_int);
    end

    always_comb begin
        case (mode)
            2'd0:    w_last = 2'd0;
            2'd1:    w_last = 2'd1;
            default: w_last = 2'd3;
        endcase
    end

    // A new request is taken on the same edge that retires the current result.
    assign w_done = ((r_state == S_MUL) && (r_pass == r_last) && (r_ps == '0)) ||
                    ((r_state == S_PIPE) && (r_dly == PIPELINE_BITS'(1)));
    assign w_accept = start && ((r_state == S_IDLE) || w_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_aa    <= '0;
            r_bb    <= '0;
            r_cc    <= '0;
            r_mode  <= '0;
            r_mac   <= 1'b0;
            r_sh    <= '0;
            r_dir   <= 1'b0;
            r_ps    <= '0;
            r_dly   <= '0;
            r_pass  <= '0;
            r_last  <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            out     <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_MUL: begin
                    if (r_pass == r_last) begin
                        if (r_ps == '0) begin
                            out     <= w_r;
                            valid   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_res   <= w_r;
                            r_dly   <= r_ps;
                            r_state <= S_PIPE;
                        end
                    end else begin
                        r_acc  <= w_prod;
                        r_pass <= r_pass + 2'd1;
                    end
                end
                S_PIPE: begin
                    if (r_dly == PIPELINE_BITS'(1)) begin
                        out     <= r_res;
                        valid   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_dly <= r_dly - PIPELINE_BITS'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_accept) begin
                r_aa    <= aa;
                r_bb    <= bb;
                r_cc    <= cc;
                r_mode  <= mode;
                r_mac   <= mac;
                r_sh    <= shift_amount;
                r_dir   <= shift_dir;
                r_ps    <= w_ps_eff;
                r_last  <= w_last;
                r_pass  <= 2'd0;
                r_acc   <= '0;
                r_state <= S_MUL;
            end
        end
    end

endmodule

// File: tb/tb_dsp_top.sv
// Directed bench for dsp_top (W=16): latency, valid pulse, hold, busy-ignore,
// shift, accumulate, back-to-back and mid-operation reset.
module tb_dsp_top;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] aa;
    logic [15:0] bb;
    logic [31:0] cc;
    logic        mac;
    logic [1:0]  shift_amount;
    logic        shift_dir;
    logic [1:0]  pipe_stages;
    logic [31:0] out;
    logic        valid;

    int          n_cmp;
    int          n_err;
    logic [31:0] model_out;

    dsp_top #(
        .WIDTH(16), .PPM_TYPE(0), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2), .PIPELINE_BITS(2)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .aa(aa), .bb(bb), .cc(cc),
        .mac(mac), .shift_amount(shift_amount), .shift_dir(shift_dir),
        .pipe_stages(pipe_stages), .out(out), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs afterwards, and check out/valid every cycle.
    task automatic do_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] c, input logic mc,
                         input logic [1:0] sh, input logic dir, input logic [1:0] ps,
                         input logic [31:0] exp, input int lat, input bit busy_start);
        @(negedge clk);
        mode = m; aa = a; bb = b; cc = c; mac = mc;
        shift_amount = sh; shift_dir = dir; pipe_stages = ps; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~m; aa = ~a; bb = ~b; cc = ~c; mac = ~mc;
        shift_amount = ~sh; shift_dir = ~dir; pipe_stages = ~ps;
        for (int n = 1; n <= lat; n++) begin
            if (busy_start && n == 1) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n < lat) begin
                chk({tag, "_hold"}, out, model_out);
                chk({tag, "_vlo"}, valid, 1'b0);
            end else begin
                chk({tag, "_out"}, out, exp);
                chk({tag, "_vhi"}, valid, 1'b1);
            end
        end
        model_out = exp;
        @(posedge clk);
        #1;
        chk({tag, "_vend"}, valid, 1'b0);
        chk({tag, "_keep"}, out, model_out);
    endtask

    logic [15:0] v_a [4];
    logic [15:0] v_b [4];
    logic        v_m [4];
    logic [31:0] v_e [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_out = 32'h0;
        rst = 1'b1; start = 1'b0; mode = 2'd0; aa = '0; bb = '0; cc = '0; mac = 1'b0;
        shift_amount = '0; shift_dir = 1'b0; pipe_stages = '0;
        #12;
        chk("rst_out", out, 32'h0);
        chk("rst_valid", valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        do_op("m0",    2'd0, 16'hFFFF, 16'h0003, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'hFFFFFFFD, 1, 1'b0);
        do_op("m1",    2'd1, 16'h00FF, 16'hFFFE, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'hFFFFFE02, 2, 1'b0);
        do_op("m1p1",  2'd1, 16'h00FF, 16'hFFFE, 32'h0, 1'b0, 2'd0, 1'b0, 2'd1, 32'hFFFFFE02, 3, 1'b0);
        do_op("m2min", 2'd2, 16'h8000, 16'h8000, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h40000000, 4, 1'b0);
        do_op("m2cc",  2'd2, 16'h7FFF, 16'h8000, 32'h1, 1'b0, 2'd0, 1'b0, 2'd0, 32'hC0008001, 4, 1'b1);
        do_op("m3",    2'd3, 16'h7FFF, 16'h8000, 32'h1, 1'b0, 2'd0, 1'b0, 2'd0, 32'hC0008001, 4, 1'b0);
        do_op("m1p3",  2'd1, 16'h0010, 16'h1000, 32'h5, 1'b0, 2'd0, 1'b0, 2'd3, 32'h00010005, 5, 1'b1);
        do_op("shl",   2'd0, 16'h0003, 16'h0004, 32'h0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h00000030, 1, 1'b0);
        do_op("sra",   2'd0, 16'h0003, 16'hFFFC, 32'h0, 1'b0, 2'd2, 1'b1, 2'd0, 32'hFFFFFFFD, 1, 1'b0);

        // Back-to-back mode 0, start every cycle; third op accumulates onto the second.
        v_a[0] = 16'h0002; v_b[0] = 16'h0003; v_m[0] = 1'b0; v_e[0] = 32'h00000006;
        v_a[1] = 16'h01FF; v_b[1] = 16'h0005; v_m[1] = 1'b0; v_e[1] = 32'hFFFFFFFB;
        v_a[2] = 16'h0007; v_b[2] = 16'h0007; v_m[2] = 1'b1; v_e[2] = 32'h0000002C;
        v_a[3] = 16'h0100; v_b[3] = 16'h0002; v_m[3] = 1'b0; v_e[3] = 32'hFFFFFE00;
        @(negedge clk);
        mode = 2'd0; cc = 32'h0; shift_amount = 2'd0; shift_dir = 1'b0; pipe_stages = 2'd0;
        aa = v_a[0]; bb = v_b[0]; mac = v_m[0]; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                chk("b2b_out", out, v_e[i-1]);
                chk("b2b_vhi", valid, 1'b1);
            end
            @(negedge clk);
            if (i < 3) begin
                aa = v_a[i+1]; bb = v_b[i+1]; mac = v_m[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("b2b_vend", valid, 1'b0);

        // Reset in the middle of a mode-2 operation.
        @(negedge clk);
        mode = 2'd2; aa = 16'h1234; bb = 16'h5678; cc = 32'h0; mac = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", out, 32'h0);
        chk("mid_rst_valid", valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_out = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", valid, 1'b0);
            chk("post_rst_out", out, 32'h0);
        end

        do_op("acc1", 2'd0, 16'h0003, 16'h0004, 32'h12345678, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0000000C, 1, 1'b0);
        do_op("acc2", 2'd0, 16'h0002, 16'h0005, 32'h12345678, 1'b1, 2'd0, 1'b0, 2'd0, 32'h00000016, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_top.md
DSP_TOP -- requirements
Module: dsp_top

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width W (even, >=8).
REQ-002 SHALL have parameter PPM_TYPE, default 0, partial-product scheme: 0 = Baugh-Wooley, 1 = radix-4 Booth; results are identical for both values.
REQ-003 SHALL have parameter SHIFT_BITS, default 2, width of shift_amount.
REQ-004 SHALL have parameter PIPE_STAGE_WIDTH, default 2, width of pipe_stages.
REQ-005 SHALL have parameter PIPELINE_BITS, default 2; maximum extra output stages = 2^PIPELINE_BITS-1.
REQ-006 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle operation request
- mode  in  2  0 = half x half, 1 = half x full, 2 = full x full, 3 = treated as 2
- aa  in  W  multiplicand, signed
- bb  in  W  multiplier, signed
- cc  in  2W  addend used when mac=0
- mac  in  1  1 = accumulate into previous result
- shift_amount  in  SHIFT_BITS  product shift distance
- shift_dir  in  1  0 = left logical, 1 = right arithmetic
- pipe_stages  in  PIPE_STAGE_WIDTH  extra output latency
- out  out  2W  result
- valid  out  1  one-cycle pulse when out updates

Function
REQ-007 SHALL sample aa, bb, cc, mode, mac, shift_amount, shift_dir, pipe_stages on the rising edge where start=1 and the unit is idle; later input changes SHALL NOT affect that operation.
REQ-008 SHALL ignore start while busy.
REQ-009 SHALL use one signed (W/2+1)x(W/2+1) multiplier core, iterated over operand halves.
REQ-010 Operand interpretation:
- mode 0: A = signed aa[W/2:0], B = signed bb[W/2:0]
- mode 1: A = signed aa[W/2:0], B = signed bb
- mode 2: A = signed aa, B = signed bb
REQ-011 Core passes SHALL be mode 0 = 1, mode 1 = 2, mode 2/3 = 4.
REQ-012 Product P SHALL be the exact signed A*B, sign-extended to 2W.
REQ-013 S SHALL be P << shift_amount (shift_dir=0) or P >>> shift_amount (shift_dir=1), truncated to 2W.
REQ-014 Result R SHALL be S + cc if mac=0, and S + out (current out value) if mac=1, modulo 2^(2W).
REQ-015 With start sampled at edge k, out SHALL take R at edge k + passes + min(pipe_stages, 2^PIPELINE_BITS-1).
REQ-016 valid SHALL be 1 for exactly the cycle following the update of out; the unit SHALL be idle, and accept start, in that same cycle.
REQ-017 out SHALL hold its value between updates.
REQ-018 Back-to-back mode-0 operations with pipe_stages=0 (start every cycle) SHALL each produce a result, one per cycle.

Reset
REQ-019 rst=1 SHALL asynchronously clear out to 0, valid to 0 and all sequencing/pipeline state to idle.
REQ-020 An operation in flight when rst asserts SHALL be discarded; no valid pulse SHALL follow for it.
REQ-021 After rst deasserts, the first mac=1 operation SHALL accumulate onto out = 0.

Verification (W=16, shift_amount=0, cc=0 unless stated)
REQ-022 mode 0, aa=0xFFFF, bb=0x0003, mac=0 -> out=0xFFFFFFFD one edge after start; valid pulses once.
REQ-023 mode 1, aa=0x00FF, bb=0xFFFE -> out=0xFFFFFE02 two edges after start; with pipe_stages=1, three edges after start.
REQ-024 mode 2, aa=0x8000, bb=0x8000 -> out=0x40000000 four edges after start; aa=0x7FFF, bb=0x8000, cc=0x00000001 -> out=0xC0008001.
REQ-025 After reset, mode 0, mac=1: ops 3*4 then 2*5 -> out=0x0000000C, then 0x00000016.
REQ-026 mode 0, 3*4, shift_amount=2, shift_dir=0 -> out=0x00000030; 3*(-4) with shift_dir=1 -> out=0xFFFFFFFD.
REQ-027 rst asserted mid mode-2 operation -> out=0 immediately, no valid pulse; next start completes normally.
